// File: rtl/hazard_pipe_reg.sv
// Multi-stage pipeline register with per-stage stall/flush, valid bit and bubble insertion.
// Optional performance counters are compiled in when HAZARD_PIPE_REG_PERF_EN is defined.
module hazard_pipe_reg #(
  parameter int unsigned      WIDTH  = 12,
  parameter int unsigned      STAGES = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [STAGES-1:0] stall_i,
  input  logic [STAGES-1:0] flush_i,
  input  logic              valid_D,
  input  logic [WIDTH-1:0]  data_D,
  output logic              valid_E,
  output logic [WIDTH-1:0]  data_E,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  logic [STAGES-1:0] v_q, v_d;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] prev_hold;
  logic [STAGES-1:0] src_v;
  logic [WIDTH-1:0]  src_d [STAGES];

  // A stall at stage k freezes k and everything upstream of it.
  always_comb begin
    hold = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      hold[k] = |(stall_i >> k);
    end
  end

  // Per-stage source: the pipeline input for stage 0, the previous stage otherwise.
  always_comb begin
    src_v        = '0;
    prev_hold    = '0;
    src_v[0]     = valid_D;
    src_d[0]     = data_D;
    prev_hold[0] = 1'b0;
    for (int k = 1; k < int'(STAGES); k++) begin
      src_v[k]     = v_q[k-1];
      src_d[k]     = d_q[k-1];
      prev_hold[k] = hold[k-1];
    end
  end

  always_comb begin
    v_d = v_q;
    for (int k = 0; k < int'(STAGES); k++) begin
      d_d[k] = d_q[k];
      if (flush_i[k]) begin
        v_d[k] = 1'b0;
        d_d[k] = BUBBLE;
      end else if (hold[k]) begin
        v_d[k] = v_q[k];
        d_d[k] = d_q[k];
      end else if (prev_hold[k]) begin
        // Upstream is frozen, so this stage drains into a bubble.
        v_d[k] = 1'b0;
        d_d[k] = BUBBLE;
      end else begin
        v_d[k] = src_v[k];
        d_d[k] = src_d[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        d_q[k] <= BUBBLE;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < int'(STAGES); k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

  assign valid_E = v_q[STAGES-1];
  assign data_E  = d_q[STAGES-1];

`ifdef HAZARD_PIPE_REG_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Saturating counters: they stick at all-ones rather than wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      if (hold[0] && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if ((|flush_i) && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_pipe_reg.sv
// Self-checking bench for hazard_pipe_reg (STAGES=2, WIDTH=12, BUBBLE=0): directed plan
// steps plus randomized traffic against a per-stage rule model.
module tb_hazard_pipe_reg;

  localparam int S = 2;
  localparam int W = 12;
`ifdef HAZARD_PIPE_REG_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [S-1:0]  stall;
  logic [S-1:0]  flush;
  logic          valid_D;
  logic [W-1:0]  data_D;
  logic          valid_E;
  logic [W-1:0]  data_E;
  logic [15:0]   stall_cnt;
  logic [15:0]   flush_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference state
  logic         m_v [S];
  logic [W-1:0] m_d [S];
  int           m_sc;
  int           m_fc;

  hazard_pipe_reg #(
    .WIDTH (W),
    .STAGES(S),
    .BUBBLE('0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .stall_i  (stall),
    .flush_i  (flush),
    .valid_D  (valid_D),
    .data_D   (data_D),
    .valid_E  (valid_E),
    .data_E   (data_E),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < S; k++) begin
      m_v[k] = 1'b0;
      m_d[k] = '0;
    end
    m_sc = 0;
    m_fc = 0;
  endtask

  // Applies the first-matching stage rules to the whole chain for one edge.
  task automatic model_edge();
    logic         nv [S];
    logic [W-1:0] nd [S];
    bit           hk, hp;
    if (reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < S; k++) begin
      hk = 1'b0;
      hp = 1'b0;
      for (int j = k; j < S; j++) hk = hk | stall[j];
      if (k > 0) for (int j = k - 1; j < S; j++) hp = hp | stall[j];
      if (flush[k])    begin nv[k] = 1'b0;    nd[k] = '0;       end
      else if (hk)     begin nv[k] = m_v[k];  nd[k] = m_d[k];   end
      else if (k == 0) begin nv[k] = valid_D; nd[k] = data_D;   end
      else if (hp)     begin nv[k] = 1'b0;    nd[k] = '0;       end
      else             begin nv[k] = m_v[k-1]; nd[k] = m_d[k-1]; end
    end
    for (int k = 0; k < S; k++) begin
      m_v[k] = nv[k];
      m_d[k] = nd[k];
    end
    if ((|stall) && m_sc < 16'hFFFF) m_sc++;
    if ((|flush) && m_fc < 16'hFFFF) m_fc++;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid_E"}, 32'(valid_E), 32'(m_v[S-1]));
    check({tag, ".data_E"}, 32'(data_E), 32'(m_d[S-1]));
    check({tag, ".stall_cnt"}, 32'(stall_cnt), PERF ? 32'(m_sc) : 32'd0);
    check({tag, ".flush_cnt"}, 32'(flush_cnt), PERF ? 32'(m_fc) : 32'd0);
  endtask

  task automatic drive(input logic [S-1:0] s, input logic [S-1:0] f, input logic v,
                       input logic [W-1:0] d);
    stall   = s;
    flush   = f;
    valid_D = v;
    data_D  = d;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_model(tag);
  endtask

  task automatic tick_fast();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive('0, '0, 1'b0, '0);
    model_reset();
    #1;
    check("reset.valid_E", 32'(valid_E), 32'd0);
    check("reset.data_E", 32'(data_E), 32'd0);
    check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset.flush_cnt", 32'(flush_cnt), 32'd0);
    tick("reset_hold");
    reset = 1'b0;

    // Streaming 1,2,3
    drive('0, '0, 1'b1, 12'd1); tick("stream1");
    drive('0, '0, 1'b1, 12'd2); tick("stream2");
    check("stream.e2", 32'(data_E), 32'd1);
    check("stream.v2", 32'(valid_E), 32'd1);
    drive('0, '0, 1'b1, 12'd3); tick("stream3");
    check("stream.e3", 32'(data_E), 32'd2);
    drive('0, '0, 1'b1, 12'h055); tick("stream4");
    check("stream.e4", 32'(data_E), 32'd3);

    // Stall stage 0 for two cycles with 0x055 held there
    drive(2'b01, '0, 1'b1, 12'h066); tick("bub1");
    check("bub1.v", 32'(valid_E), 32'd0);
    check("bub1.d", 32'(data_E), 32'd0);
    tick("bub2");
    check("bub2.v", 32'(valid_E), 32'd0);
    check("bub2.d", 32'(data_E), 32'd0);
    drive('0, '0, 1'b1, 12'h077); tick("bub3");
    check("bub3.d", 32'(data_E), 32'h055);
    check("bub3.v", 32'(valid_E), 32'd1);
    drive('0, '0, 1'b0, 12'h000); tick("bub4");
    check("bub4.once", 32'(data_E), 32'h077);

    // Stall on the last stage back-propagates to stage 0
    drive('0, '0, 1'b1, 12'h0A1); tick("bp0");
    drive('0, '0, 1'b1, 12'h0A2); tick("bp1");
    drive(2'b10, '0, 1'b1, 12'h0A3);
    for (int i = 0; i < 3; i++) begin
      tick("bp_hold");
      check("bp.hold_d", 32'(data_E), 32'h0A1);
      check("bp.hold_v", 32'(valid_E), 32'd1);
    end
    drive('0, '0, 1'b1, 12'h0A4); tick("bp_rel1");
    check("bp.rel1", 32'(data_E), 32'h0A2);
    drive('0, '0, 1'b1, 12'h0A5); tick("bp_rel2");
    check("bp.rel2", 32'(data_E), 32'h0A4);

    // Flush beats stall on the last stage; stage 0 still holds 0x0A5
    drive(2'b10, 2'b10, 1'b1, 12'h0B0); tick("fos");
    check("fos.v", 32'(valid_E), 32'd0);
    check("fos.d", 32'(data_E), 32'd0);
    drive('0, '0, 1'b1, 12'h0B1); tick("fos_rel");
    check("fos.held", 32'(data_E), 32'h0A5);

    // Asynchronous reset with 0xABC in flight
    drive('0, '0, 1'b1, 12'hABC); tick("rst_pre");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_async.v", 32'(valid_E), 32'd0);
    check("rst_async.d", 32'(data_E), 32'd0);
    check("rst_async.sc", 32'(stall_cnt), 32'd0);
    tick("rst_edge");
    reset = 1'b0;
    drive('0, '0, 1'b1, 12'h123); tick("rst_post1");
    check("rst_post1.v", 32'(valid_E), 32'd0);
    drive('0, '0, 1'b1, 12'h124); tick("rst_post2");
    check("rst_post2.v", 32'(valid_E), 32'd1);
    check("rst_post2.d", 32'(data_E), 32'h123);

    // Counters: 5 stall cycles, 2 flush cycles from a fresh reset
    reset = 1'b1;
    model_reset();
    #1;
    reset = 1'b0;
    drive(2'b01, '0, 1'b1, 12'h011);
    repeat (5) tick("cnt_stall");
    drive('0, 2'b01, 1'b1, 12'h022);
    repeat (2) tick("cnt_flush");
    check("cnt.stall", 32'(stall_cnt), PERF ? 32'd5 : 32'd0);
    check("cnt.flush", 32'(flush_cnt), PERF ? 32'd2 : 32'd0);

    // Randomized traffic with an occasional mid-stream reset
    for (int i = 0; i < 400; i++) begin
      drive(S'(($urandom_range(0, 4) == 0) ? $urandom : 0),
            S'(($urandom_range(0, 9) == 0) ? $urandom : 0),
            1'($urandom), W'($urandom));
      reset = ($urandom_range(0, 99) == 0);
      if (reset) begin
        model_reset();
        #1;
        check("rand.async_v", 32'(valid_E), 32'd0);
      end
      tick("rand");
      reset = 1'b0;
    end

`ifdef HAZARD_PIPE_REG_PERF_EN
    // Long stall run drives stall_cnt into saturation
    drive(2'b01, '0, 1'b1, 12'h033);
    repeat (65540) tick_fast();
    check("sat.stall", 32'(stall_cnt), 32'hFFFF);
    tick("sat.after");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
